// File: rtl/score_keeper_pkg.sv
// Shared constants for the game-score producer: FSM state encodings and bus widths.
package score_keeper_pkg;

    localparam int unsigned SCORE_W = 14;
    localparam int unsigned BCD_W   = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

endpackage

// File: rtl/score_keeper_bcd.sv
// 4-digit BCD incrementer; clr has priority over inc.
module bcd_counter4
    import score_keeper_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [BCD_W-1:0] bcd_o
);

    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             carry;

    // Ripple the +1 through the digits; a digit at 9 rolls to 0 and passes the carry on.
    always_comb begin
        bcd_d = bcd_q;
        carry = inc_i;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_q[i*4 +: 4] == 4'd9) begin
                    bcd_d[i*4 +: 4] = 4'd0;
                end else begin
                    bcd_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
        if (clr_i) begin
            bcd_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/score_keeper.sv
// Game-state FSM and score producer: tick prescaler, saturating score, BCD copy,
// day/night request and milestone pulse, all driven from wrap counters instead of division.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 4_000_000,
    parameter int unsigned SCORE_MAX   = 9999,
    parameter int unsigned DARK_PERIOD = 700,
    parameter int unsigned DARK_LEN    = 150,
    parameter int unsigned MILE_STEP   = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               collide,
    output logic [SCORE_W-1:0] game_score,
    output logic [BCD_W-1:0]   score_bcd,
    output logic               running,
    output logic               game_over,
    output logic               dark_req,
    output logic               milestone
);

    localparam int unsigned PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned DARKP_W = (DARK_PERIOD > 1) ? $clog2(DARK_PERIOD) : 1;
    localparam int unsigned MILE_W  = (MILE_STEP > 1) ? $clog2(MILE_STEP) : 1;
    localparam int unsigned DCNT_W  = $clog2(DARK_LEN + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
    localparam logic [DARKP_W-1:0] DARK_LAST  = DARKP_W'(DARK_PERIOD - 1);
    localparam logic [MILE_W-1:0]  MILE_LAST  = MILE_W'(MILE_STEP - 1);
    localparam logic [DCNT_W-1:0]  DARK_LOAD  = DCNT_W'(DARK_LEN);
    localparam logic [DCNT_W-1:0]  DARK_ONE   = DCNT_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(SCORE_MAX);

    logic [1:0]         state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [DARKP_W-1:0] mod_dark_q, mod_dark_d;
    logic [MILE_W-1:0]  mod_mile_q, mod_mile_d;
    logic [DCNT_W-1:0]  dark_cnt_q, dark_cnt_d;
    logic               dark_q, dark_d;
    logic               mile_q, mile_d;

    logic start_run;
    logic advance;
    logic tick;

    always_comb begin
        start_run = start && (state_q != S_RUN);
        advance   = (state_q == S_RUN) && !collide && (score_q != SCORE_LAST);
        tick      = advance && (presc_q == PRESC_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)   state_d = S_RUN;
            S_RUN:   if (collide) state_d = S_OVER;
            S_OVER:  if (start)   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Everything below is frozen outside RUN, on a collide cycle and once the score saturates.
    always_comb begin
        presc_d    = presc_q;
        score_d    = score_q;
        mod_dark_d = mod_dark_q;
        mod_mile_d = mod_mile_q;
        dark_cnt_d = dark_cnt_q;
        dark_d     = dark_q;
        mile_d     = 1'b0;
        if (start_run) begin
            presc_d    = '0;
            score_d    = '0;
            mod_dark_d = '0;
            mod_mile_d = '0;
            dark_cnt_d = '0;
            dark_d     = 1'b0;
        end else if (advance) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                score_d = score_q + 1'b1;
                if (mod_mile_q == MILE_LAST) begin
                    mod_mile_d = '0;
                    mile_d     = 1'b1;
                end else begin
                    mod_mile_d = mod_mile_q + 1'b1;
                end
                if (mod_dark_q == DARK_LAST) begin
                    mod_dark_d = '0;
                    dark_d     = 1'b1;
                    dark_cnt_d = DARK_LOAD;
                end else begin
                    mod_dark_d = mod_dark_q + 1'b1;
                    if (dark_q) begin
                        dark_cnt_d = dark_cnt_q - 1'b1;
                        if (dark_cnt_q == DARK_ONE) begin
                            dark_d = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            score_q    <= '0;
            mod_dark_q <= '0;
            mod_mile_q <= '0;
            dark_cnt_q <= '0;
            dark_q     <= 1'b0;
            mile_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            score_q    <= score_d;
            mod_dark_q <= mod_dark_d;
            mod_mile_q <= mod_mile_d;
            dark_cnt_q <= dark_cnt_d;
            dark_q     <= dark_d;
            mile_q     <= mile_d;
        end
    end

    bcd_counter4 u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (tick),
        .clr_i (start_run),
        .bcd_o (score_bcd)
    );

    assign game_score = score_q;
    assign running    = (state_q == S_RUN);
    assign game_over  = (state_q == S_OVER);
    assign dark_req   = dark_q;
    assign milestone  = mile_q;

    // Dark phases must not overlap.
    a_dark_len : assert property (@(posedge clk) disable iff (!rst_n) (DARK_LEN < DARK_PERIOD));

endmodule
